// File: rtl/system_exec_ctrl.sv
// RV32I SYSTEM instruction sequencer: ECALL/EBREAK traps and CSR read-modify-write over a
// req/ack port. Define SYSEXEC_TIMEOUT_EN to add a CSR ack timeout that traps as illegal.

package system_exec_pkg;
    typedef enum logic [3:0] {
        sysk_invalid,
        sysk_ecall,
        sysk_ebreak,
        sysk_csrrw,
        sysk_csrrs,
        sysk_csrrc,
        sysk_csrrwi,
        sysk_csrrsi,
        sysk_csrrci
    } system_kind_t;
endpackage

module system_exec_ctrl
    import system_exec_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  system_kind_t      in_kind,
    input  logic [11:0]       in_csr_addr,
    input  logic [4:0]        in_rs1_idx,
    input  logic [XLEN-1:0]   in_rs1_val,
    input  logic [4:0]        in_rd_idx,
    input  logic [XLEN-1:0]   in_pc,
    output logic              csr_req,
    output logic              csr_we,
    output logic [11:0]       csr_addr,
    output logic [XLEN-1:0]   csr_wdata,
    input  logic [XLEN-1:0]   csr_rdata,
    input  logic              csr_ack,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              trap_valid,
    output logic [3:0]        trap_cause,
    output logic [XLEN-1:0]   trap_epc,
    output logic              done
);

    typedef enum logic [2:0] {StIdle, StRead, StWrite, StResp, StTrap} state_e;

    localparam logic [3:0] CauseIllegal = 4'd2;
    localparam logic [3:0] CauseBreak   = 4'd3;
    localparam logic [3:0] CauseEcallM  = 4'd11;

    state_e            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              csr_req_q, csr_req_d;
    logic              csr_we_q, csr_we_d;
    logic [11:0]       csr_addr_q, csr_addr_d;
    logic [XLEN-1:0]   csr_wdata_q, csr_wdata_d;
    logic              wb_valid_q, wb_valid_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic              trap_valid_q, trap_valid_d;
    logic [3:0]        trap_cause_q, trap_cause_d;
    logic [XLEN-1:0]   trap_epc_q, trap_epc_d;
    logic              done_q, done_d;
    system_kind_t      kind_q, kind_d;
    logic [XLEN-1:0]   src_q, src_d;
    logic              do_read_q, do_read_d;
    logic              do_write_q, do_write_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   old_q, old_d;

    logic              timeout_hit;

    // Decode of the presented instruction, only consumed on accept.
    logic              acc_imm, acc_rw, acc_read, acc_write, acc_ro, acc_csr;
    logic [XLEN-1:0]   acc_src;

    always_comb begin
        acc_imm   = (in_kind == sysk_csrrwi) || (in_kind == sysk_csrrsi) ||
                    (in_kind == sysk_csrrci);
        acc_rw    = (in_kind == sysk_csrrw) || (in_kind == sysk_csrrwi);
        acc_csr   = acc_imm || acc_rw || (in_kind == sysk_csrrs) || (in_kind == sysk_csrrc);
        acc_src   = acc_imm ? {{(XLEN-5){1'b0}}, in_rs1_idx} : in_rs1_val;
        acc_read  = !(acc_rw && (in_rd_idx == 5'd0));
        acc_write = acc_rw || (in_rs1_idx != 5'd0);
        acc_ro    = acc_write && (in_csr_addr[11:10] == 2'b11);
    end

    function automatic logic [XLEN-1:0] merge_wdata(input system_kind_t k,
                                                    input logic [XLEN-1:0] old,
                                                    input logic [XLEN-1:0] src);
        logic [XLEN-1:0] r;
        r = src;
        if ((k == sysk_csrrs) || (k == sysk_csrrsi)) begin
            r = old | src;
        end else if ((k == sysk_csrrc) || (k == sysk_csrrci)) begin
            r = old & ~src;
        end
        return r;
    endfunction

`ifdef SYSEXEC_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            in_access;

    // Counter restarts whenever an access phase is (re)entered or acked.
    always_comb begin
        in_access   = (state_q == StRead) || (state_q == StWrite);
        cnt_d       = '0;
        if (in_access && !csr_ack) begin
            cnt_d = cnt_q + 1'b1;
        end
        timeout_hit = in_access && !csr_ack && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        in_ready_d   = in_ready_q;
        csr_req_d    = csr_req_q;
        csr_we_d     = csr_we_q;
        csr_addr_d   = csr_addr_q;
        csr_wdata_d  = csr_wdata_q;
        wb_valid_d   = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        trap_valid_d = 1'b0;
        trap_cause_d = trap_cause_q;
        trap_epc_d   = trap_epc_q;
        done_d       = 1'b0;
        kind_d       = kind_q;
        src_d        = src_q;
        do_read_d    = do_read_q;
        do_write_d   = do_write_q;
        rd_d         = rd_q;
        pc_d         = pc_q;
        old_d        = old_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready_q) begin
                    in_ready_d = 1'b0;
                    kind_d     = in_kind;
                    src_d      = acc_src;
                    do_read_d  = acc_read;
                    do_write_d = acc_write;
                    rd_d       = in_rd_idx;
                    pc_d       = in_pc;
                    if ((in_kind == sysk_ecall) || (in_kind == sysk_ebreak) ||
                        !acc_csr || acc_ro) begin
                        state_d      = StTrap;
                        trap_valid_d = 1'b1;
                        trap_epc_d   = in_pc;
                        done_d       = 1'b1;
                        if (in_kind == sysk_ecall) begin
                            trap_cause_d = CauseEcallM;
                        end else if (in_kind == sysk_ebreak) begin
                            trap_cause_d = CauseBreak;
                        end else begin
                            trap_cause_d = CauseIllegal;
                        end
                    end else if (acc_read) begin
                        state_d    = StRead;
                        csr_req_d  = 1'b1;
                        csr_we_d   = 1'b0;
                        csr_addr_d = in_csr_addr;
                    end else begin
                        // csrrw/csrrwi with rd=x0: write-only, no read side effects
                        state_d     = StWrite;
                        csr_req_d   = 1'b1;
                        csr_we_d    = 1'b1;
                        csr_addr_d  = in_csr_addr;
                        csr_wdata_d = acc_src;
                    end
                end
            end
            StRead, StWrite: begin
                if (csr_ack) begin
                    if ((state_q == StRead) && do_write_q) begin
                        state_d     = StWrite;
                        old_d       = csr_rdata;
                        csr_we_d    = 1'b1;
                        csr_wdata_d = merge_wdata(kind_q, csr_rdata, src_q);
                    end else begin
                        state_d    = StResp;
                        csr_req_d  = 1'b0;
                        csr_we_d   = 1'b0;
                        wb_valid_d = do_read_q && (rd_q != 5'd0);
                        wb_rd_d    = rd_q;
                        wb_data_d  = (state_q == StRead) ? csr_rdata : old_q;
                        done_d     = 1'b1;
                        if (state_q == StRead) begin
                            old_d = csr_rdata;
                        end
                    end
                end else if (timeout_hit) begin
                    state_d      = StTrap;
                    csr_req_d    = 1'b0;
                    csr_we_d     = 1'b0;
                    trap_valid_d = 1'b1;
                    trap_cause_d = CauseIllegal;
                    trap_epc_d   = pc_q;
                    done_d       = 1'b1;
                end
            end
            StResp, StTrap: begin
                state_d    = StIdle;
                in_ready_d = 1'b1;
            end
            default: begin
                state_d    = StIdle;
                in_ready_d = 1'b1;
                csr_req_d  = 1'b0;
                csr_we_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            in_ready_q   <= 1'b1;
            csr_req_q    <= 1'b0;
            csr_we_q     <= 1'b0;
            csr_addr_q   <= '0;
            csr_wdata_q  <= '0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            trap_valid_q <= 1'b0;
            trap_cause_q <= '0;
            trap_epc_q   <= '0;
            done_q       <= 1'b0;
            kind_q       <= sysk_invalid;
            src_q        <= '0;
            do_read_q    <= 1'b0;
            do_write_q   <= 1'b0;
            rd_q         <= '0;
            pc_q         <= '0;
            old_q        <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            csr_req_q    <= csr_req_d;
            csr_we_q     <= csr_we_d;
            csr_addr_q   <= csr_addr_d;
            csr_wdata_q  <= csr_wdata_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            trap_valid_q <= trap_valid_d;
            trap_cause_q <= trap_cause_d;
            trap_epc_q   <= trap_epc_d;
            done_q       <= done_d;
            kind_q       <= kind_d;
            src_q        <= src_d;
            do_read_q    <= do_read_d;
            do_write_q   <= do_write_d;
            rd_q         <= rd_d;
            pc_q         <= pc_d;
            old_q        <= old_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign csr_req    = csr_req_q;
    assign csr_we     = csr_we_q;
    assign csr_addr   = csr_addr_q;
    assign csr_wdata  = csr_wdata_q;
    assign wb_valid   = wb_valid_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign trap_valid = trap_valid_q;
    assign trap_cause = trap_cause_q;
    assign trap_epc   = trap_epc_q;
    assign done       = done_q;

endmodule

// File: tb/tb_system_exec_ctrl.sv
// Directed bench for system_exec_ctrl: CSR forms, traps, read-only CSR, reset abort, timeout.

module tb_system_exec_ctrl;
    import system_exec_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    system_kind_t      in_kind;
    logic [11:0]       in_csr_addr;
    logic [4:0]        in_rs1_idx;
    logic [31:0]       in_rs1_val;
    logic [4:0]        in_rd_idx;
    logic [31:0]       in_pc;
    logic              csr_req;
    logic              csr_we;
    logic [11:0]       csr_addr;
    logic [31:0]       csr_wdata;
    logic [31:0]       csr_rdata;
    logic              csr_ack;
    logic              wb_valid;
    logic [4:0]        wb_rd;
    logic [31:0]       wb_data;
    logic              trap_valid;
    logic [3:0]        trap_cause;
    logic [31:0]       trap_epc;
    logic              done;

    system_exec_ctrl #(.XLEN(32), .TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_kind    (in_kind),
        .in_csr_addr(in_csr_addr),
        .in_rs1_idx (in_rs1_idx),
        .in_rs1_val (in_rs1_val),
        .in_rd_idx  (in_rd_idx),
        .in_pc      (in_pc),
        .csr_req    (csr_req),
        .csr_we     (csr_we),
        .csr_addr   (csr_addr),
        .csr_wdata  (csr_wdata),
        .csr_rdata  (csr_rdata),
        .csr_ack    (csr_ack),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .trap_valid (trap_valid),
        .trap_cause (trap_cause),
        .trap_epc   (trap_epc),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    int          r_lat;
    logic        r_req, r_write, r_wb, r_trap;
    logic [31:0] r_wdata, r_wbdata, r_epc;
    logic [11:0] r_addr;
    logic [4:0]  r_rd;
    logic [3:0]  r_cause;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction and returns just after its accept edge.
    task automatic issue(input system_kind_t k, input logic [11:0] a, input logic [4:0] rs1,
                         input logic [31:0] rv, input logic [4:0] rd, input logic [31:0] pc);
        in_kind     = k;
        in_csr_addr = a;
        in_rs1_idx  = rs1;
        in_rs1_val  = rv;
        in_rd_idx   = rd;
        in_pc       = pc;
        in_valid    = 1'b1;
        step();
        in_valid    = 1'b0;
        in_kind     = sysk_csrrw;
        in_csr_addr = 12'hC00;
        in_rs1_idx  = 5'd31;
        in_rs1_val  = 32'h5A5A_5A5A;
        in_rd_idx   = 5'd31;
        in_pc       = 32'hFFFF_FFF0;
    endtask

    // Acts as the CSR file (ack latency 1 when ack_ok) until done, recording what happened.
    task automatic run_csr(input logic [31:0] rdata, input bit ack_ok);
        r_lat = -1; r_req = 0; r_write = 0; r_wb = 0; r_trap = 0;
        r_wdata = 0; r_wbdata = 0; r_epc = 0; r_addr = 0; r_rd = 0; r_cause = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                r_lat    = k + 1;
                r_wb     = wb_valid;
                r_rd     = wb_rd;
                r_wbdata = wb_data;
                r_trap   = trap_valid;
                r_cause  = trap_cause;
                r_epc    = trap_epc;
                break;
            end
            if (csr_req && !r_req) r_addr = csr_addr;
            if (csr_req) r_req = 1'b1;
            if (csr_req && csr_we) begin
                r_write = 1'b1;
                r_wdata = csr_wdata;
            end
            csr_ack   = ack_ok ? csr_req : 1'b0;
            csr_rdata = rdata;
            step();
        end
        csr_ack = 1'b0;
        check_eq("done_seen", 32'(r_lat > 0), 32'd1);
        step();
        check_eq("ready_after_done", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; csr_ack = 1'b0; csr_rdata = '0;
        in_kind = sysk_invalid; in_csr_addr = '0; in_rs1_idx = '0; in_rs1_val = '0;
        in_rd_idx = '0; in_pc = '0;
        repeat (3) step();
        check_eq("rst_ready", 32'(in_ready), 32'd1);
        check_eq("rst_req", 32'(csr_req), 32'd0);
        check_eq("rst_pulses", 32'({wb_valid, trap_valid, done, csr_we}), 32'd0);
        check_eq("rst_data", csr_wdata | wb_data | trap_epc | 32'(csr_addr), 32'd0);
        rst = 1'b1;
        step();

        // csrrw x5 <- 0x340 with rs1=0xDEADBEEF
        issue(sysk_csrrw, 12'h340, 5'd9, 32'hDEAD_BEEF, 5'd5, 32'h100);
        run_csr(32'h11, 1'b1);
        check_eq("rw_addr", 32'(r_addr), 32'h340);
        check_eq("rw_wdata", r_wdata, 32'hDEAD_BEEF);
        check_eq("rw_wb", {r_wb, 26'd0, r_rd}, {1'b1, 26'd0, 5'd5});
        check_eq("rw_wbdata", r_wbdata, 32'h11);
        check_eq("rw_lat", 32'(r_lat), 32'd3);

        // csrrsi zimm=0: read only
        issue(sysk_csrrsi, 12'h300, 5'd0, 32'hFFFF_FFFF, 5'd3, 32'h104);
        run_csr(32'hA5, 1'b1);
        check_eq("rsi0_nowrite", 32'(r_write), 32'd0);
        check_eq("rsi0_wb", {r_wb, 26'd0, r_rd}, {1'b1, 26'd0, 5'd3});
        check_eq("rsi0_data", r_wbdata, 32'hA5);
        check_eq("rsi0_lat", 32'(r_lat), 32'd2);

        issue(sysk_csrrc, 12'h304, 5'd2, 32'h0F, 5'd1, 32'h108);
        run_csr(32'hFF, 1'b1);
        check_eq("rc_wdata", r_wdata, 32'hF0);

        issue(sysk_csrrs, 12'h304, 5'd4, 32'h100, 5'd1, 32'h10C);
        run_csr(32'h1, 1'b1);
        check_eq("rs_wdata", r_wdata, 32'h101);
        check_eq("rs_wbdata", r_wbdata, 32'h1);

        issue(sysk_csrrci, 12'h305, 5'd5, 32'h0, 5'd2, 32'h110);
        run_csr(32'hFF, 1'b1);
        check_eq("rci_wdata", r_wdata, 32'hFA);

        // csrrwi rd=x0: write-only, no writeback
        issue(sysk_csrrwi, 12'h300, 5'h1B, 32'h0, 5'd0, 32'h114);
        run_csr(32'h77, 1'b1);
        check_eq("rwi0_wdata", r_wdata, 32'h1B);
        check_eq("rwi0_wb", 32'(r_wb), 32'd0);
        check_eq("rwi0_lat", 32'(r_lat), 32'd2);

        issue(sysk_ecall, 12'h000, 5'd0, 32'h0, 5'd0, 32'h80);
        run_csr(32'h0, 1'b1);
        check_eq("ecall_trap", {r_trap, 23'd0, r_cause}, {1'b1, 23'd0, 4'd11});
        check_eq("ecall_epc", r_epc, 32'h80);
        check_eq("ecall_noreq", 32'({r_req, r_wb}), 32'd0);
        check_eq("ecall_lat", 32'(r_lat), 32'd1);

        issue(sysk_ebreak, 12'h001, 5'd0, 32'h0, 5'd0, 32'h84);
        run_csr(32'h0, 1'b1);
        check_eq("ebreak_cause", {r_trap, 23'd0, r_cause}, {1'b1, 23'd0, 4'd3});

        issue(sysk_invalid, 12'h340, 5'd1, 32'h1, 5'd1, 32'h88);
        run_csr(32'h0, 1'b1);
        check_eq("inval_cause", {r_trap, 23'd0, r_cause}, {1'b1, 23'd0, 4'd2});
        check_eq("inval_noreq", 32'(r_req), 32'd0);

        issue(sysk_csrrw, 12'hC00, 5'd1, 32'h1234, 5'd6, 32'h8C);
        run_csr(32'h0, 1'b1);
        check_eq("ro_cause", {r_trap, 23'd0, r_cause}, {1'b1, 23'd0, 4'd2});
        check_eq("ro_noreq", 32'({r_req, r_wb}), 32'd0);
        check_eq("ro_epc", r_epc, 32'h8C);

        issue(sysk_csrrs, 12'hC00, 5'd0, 32'hFFFF, 5'd7, 32'h90);
        run_csr(32'h55, 1'b1);
        check_eq("ro_read_ok", {r_trap, r_write, r_wb}, 32'b001);
        check_eq("ro_read_data", r_wbdata, 32'h55);

        // Stray ack while idle must not start anything.
        csr_ack = 1'b1;
        repeat (3) step();
        check_eq("stray_ack", 32'({done, wb_valid, csr_req}), 32'd0);
        csr_ack = 1'b0;

        // Reset in the middle of a READ with ack withheld.
        issue(sysk_csrrs, 12'h341, 5'd3, 32'h1, 5'd8, 32'h94);
        check_eq("mid_req", 32'({csr_req, csr_we, in_ready}), 32'b100);
        repeat (2) step();
        rst = 1'b0;
        step();
        check_eq("mid_rst_req", 32'({csr_req, csr_we, in_ready, done}), 32'b0010);
        check_eq("mid_rst_data", 32'(csr_addr) | wb_data | trap_epc | 32'(wb_rd), 32'd0);
        rst = 1'b1;
        step();

`ifdef SYSEXEC_TIMEOUT_EN
        issue(sysk_csrrs, 12'h342, 5'd1, 32'h2, 5'd9, 32'h98);
        run_csr(32'h0, 1'b0);
        check_eq("to_cause", {r_trap, 23'd0, r_cause}, {1'b1, 23'd0, 4'd2});
        check_eq("to_epc", r_epc, 32'h98);
        check_eq("to_lat", 32'(r_lat), 32'd17);
        check_eq("to_nowb_noreq", 32'({r_wb, csr_req}), 32'd0);
`else
        issue(sysk_csrrs, 12'h342, 5'd1, 32'h2, 5'd9, 32'h98);
        repeat (20) step();
        check_eq("wait_req", 32'({csr_req, done}), 32'b10);
        run_csr(32'h40, 1'b1);
        check_eq("wait_wdata", r_wdata, 32'h42);
        check_eq("wait_wbdata", r_wbdata, 32'h40);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/system_exec_ctrl.md
Name: system_exec_ctrl

Overview:
Sequences execution of decoded RV32I SYSTEM instructions: ECALL, EBREAK, and the six CSR read-modify-write forms.
- Accepts one instruction per valid/ready handshake from the decode stage.
- Drives a multi-cycle request/ack port on the CSR register file.
- Returns the old CSR value for rd writeback, or raises a trap request to the fetch/trap unit.
- Single outstanding instruction; the issue stage stalls on in_ready low.

Parameters:
XLEN, 32, data width of CSR, rs1 and rd paths
TIMEOUT_CYCLES, 16, CSR ack timeout limit (used only with SYSEXEC_TIMEOUT_EN)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active low (asserted when 0, sampled on rising clk)
in_valid  in  1  decode presents an instruction
in_ready  out  1  controller can accept (high only in IDLE)
in_kind  in  system_kind_t  decoded system kind (sysk_* values, incl. sysk_invalid)
in_csr_addr  in  12  CSR address (instr[31:20])
in_rs1_idx  in  5  rs1 index; also the zimm source for *i forms
in_rs1_val  in  XLEN  rs1 register value
in_rd_idx  in  5  destination register index
in_pc  in  XLEN  PC of the instruction
csr_req  out  1  CSR access request, held until csr_ack
csr_we  out  1  1 = write phase, 0 = read phase
csr_addr  out  12  latched CSR address
csr_wdata  out  XLEN  write data
csr_rdata  in  XLEN  read data, valid with csr_ack on a read
csr_ack  in  1  CSR file completes the current request
wb_valid  out  1  one-cycle pulse: write wb_data to wb_rd
wb_rd  out  5  destination index
wb_data  out  XLEN  old CSR value
trap_valid  out  1  one-cycle pulse: trap request
trap_cause  out  4  mcause code: 2 illegal, 3 breakpoint, 11 ecall-M
trap_epc  out  XLEN  PC of the trapping instruction
done  out  1  one-cycle pulse: instruction retired (also asserted with trap)

Behaviour:
- Reset (rst=0 at a rising edge) returns the FSM to IDLE and clears all outputs: in_ready=1, csr_req=0, csr_we=0, csr_addr=0, csr_wdata=0, wb_valid=0, wb_rd=0, wb_data=0, trap_valid=0, trap_cause=0, trap_epc=0, done=0.
- Reset mid-transaction abandons the access. csr_req drops on the next edge; the CSR file must tolerate a dropped request.
- Accept: the instruction is accepted when in_valid && in_ready at an edge. All in_* fields are latched; later input changes are ignored.
- States: IDLE, READ, WRITE, RESP, TRAP.
- Classification at accept:
  - Operand src = in_rs1_val for csrrw/csrrs/csrrc.
  - Operand src = zero-extended in_rs1_idx for csrrwi/csrrsi/csrrci.
  - do_read = 0 for csrrw/csrrwi when rd==0; otherwise 1.
  - do_write = 1 for csrrw/csrrwi.
  - do_write = (rs1_idx != 0) for set/clear forms.
  - ro_violation = do_write && csr_addr[11:10]==2'b11.
- Transitions from IDLE on accept:
  - ecall -> TRAP, cause 11.
  - ebreak -> TRAP, cause 3.
  - sysk_invalid or ro_violation -> TRAP, cause 2; no CSR access is issued.
  - do_read -> READ.
  - else -> WRITE (csrrw x0 case).
- READ: csr_req=1, csr_we=0. On csr_ack, csr_rdata is latched as old. Next state is WRITE if do_write, else RESP.
- WRITE: csr_req=1, csr_we=1. csr_wdata is:
  - src for rw forms;
  - old | src for set forms;
  - old & ~src for clear forms.
  On csr_ack -> RESP.
- RESP: one cycle. wb_valid = do_read && rd!=0, wb_data = old, done=1 -> IDLE.
- TRAP: one cycle. trap_valid=1, trap_epc=latched pc, done=1, wb_valid=0 -> IDLE.
- csr_ack arriving outside READ/WRITE is ignored.
- csr_ack in the same cycle csr_req first rises is legal; minimum latency is 1 cycle per phase.
- Latency from accept (ack=1 cycle): done at +2 for read-only, +3 for read+write, +1 for trap.
- in_ready is low in every state except IDLE. Back-to-back accept is allowed on the cycle after done.

Optional Feature:
SYSEXEC_TIMEOUT_EN
- Defined: an internal counter, reset on entry to READ/WRITE, increments each cycle without csr_ack. At TIMEOUT_CYCLES it forces TRAP with cause 2, drops csr_req, and issues no writeback.
- Undefined: no counter; the FSM waits indefinitely for csr_ack.

Test Plan:
- csrrw rd=5, rs1_val=0xDEADBEEF, addr 0x340, rdata 0x11, ack latency 1 -> write 0xDEADBEEF; wb_valid rd=5 data 0x11; done at accept+3.
- csrrsi rd=3, zimm=0, rdata 0xA5 -> read only, no write phase; wb data 0xA5; done at accept+2.
- csrrc rs1_val=0x0F, rdata 0xFF -> csr_wdata 0xF0; csrrs rs1_val=0x100, rdata 0x1 -> csr_wdata 0x101.
- ecall at pc 0x80 -> trap_valid, cause 11, epc 0x80, no csr_req. ebreak -> cause 3. sysk_invalid -> cause 2.
- csrrw to addr 0xC00 -> cause 2 trap, csr_req never asserted. csrrs rs1=0 to 0xC00 -> normal read, no trap.
- rst=0 during READ with ack withheld -> next cycle csr_req=0, in_ready=1, all outputs zero. With SYSEXEC_TIMEOUT_EN, ack withheld 16 cycles -> cause 2 trap.
